// File: rtl/mem_dram_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access engine:
// access size encodings, FSM state encoding and the load-extend helper.
package mem_dram_access_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_CANCEL
    } state_t;

    // Extend an already right-aligned load value according to its size.
    // The signed flag wins if both flags are set; size 3 behaves as word.
    function automatic logic [31:0] load_extend(
        input logic [31:0] v,
        input logic [1:0]  size,
        input logic        sext
    );
        logic [31:0] res;
        res = v;
        case (size)
            SZ_B:    res = {{24{sext & v[7]}},  v[7:0]};
            SZ_H:    res = {{16{sext & v[15]}}, v[15:0]};
            default: res = v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_dram_access_load_align.sv
// Combinational load alignment and extension of a raw SRAM read word.
module mem_load_align
    import mem_dram_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic        i_zext,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [31:0] w_aligned;

    // Select the addressed lane and extend it; without an extension mode
    // the raw word is returned.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_size)
            SZ_B:    w_aligned = {24'h0, w_byte};
            SZ_H:    w_aligned = i_addr_lo[1] ? {16'h0, i_rdata[31:16]} : {16'h0, i_rdata[15:0]};
            default: w_aligned = i_rdata;
        endcase
        if (i_sext | i_zext) begin
            o_result = load_extend(w_aligned, i_size, i_sext);
        end else begin
            o_result = i_rdata;
        end
    end

endmodule

// File: rtl/mem_dram_access.sv
// MEM-stage data-memory access engine: issues SRAM-like requests, waits for
// responses, buffers load data while WB stalls and drains responses that
// were orphaned by a writeback flush.
module mem_dram_access
    import mem_dram_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_dram_re,
    input  logic        mem_dram_we,
    input  logic [31:0] mem_dram_waddr,
    input  logic [31:0] mem_dram_wdata,
    input  logic [1:0]  mem_rdram_num,
    input  logic [1:0]  mem_wdram_num,
    input  logic        mem_rdram_need_signed_extend,
    input  logic        mem_rdram_need_zero_extend,
    input  logic        mem_ex,
    input  logic        wb_ex,
    input  logic        wb_is_ertn,
    input  logic        wb_allowin,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_ready_go,
    output logic [31:0] mem_load_result
);

    state_t      r_state;
    logic        r_cancel_pending;
    logic [31:0] r_result_buf;

    // Request fields captured at issue time
    logic        r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_rd_num;
    logic        r_sext;
    logic        r_zext;

    logic        w_flush;
    logic        w_acc;
    logic        w_live_wr;
    logic [1:0]  w_live_size;
    logic [3:0]  w_live_wstrb;
    logic [31:0] w_live_wdata;
    logic [31:0] w_align_result;
    logic [31:0] w_load_data;

    assign w_flush = wb_ex | wb_is_ertn;
    assign w_acc   = mem_valid & (mem_dram_re | mem_dram_we) & ~mem_ex & ~w_flush;

    // Encode the request straight from the MEM register fields.
    always_comb begin
        w_live_wr    = mem_dram_we;
        w_live_size  = mem_dram_we ? mem_wdram_num : mem_rdram_num;
        w_live_wstrb = '0;
        w_live_wdata = mem_dram_wdata;
        if (mem_dram_we) begin
            case (mem_wdram_num)
                SZ_B: begin
                    w_live_wstrb = 4'b0001 << mem_dram_waddr[1:0];
                    w_live_wdata = {4{mem_dram_wdata[7:0]}};
                end
                SZ_H: begin
                    w_live_wstrb = 4'b0011 << {mem_dram_waddr[1], 1'b0};
                    w_live_wdata = {2{mem_dram_wdata[15:0]}};
                end
                default: begin
                    w_live_wstrb = 4'b1111;
                    w_live_wdata = mem_dram_wdata;
                end
            endcase
        end
    end

    mem_load_align u_align (
        .i_rdata   (data_sram_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_rd_num),
        .i_sext    (r_sext),
        .i_zext    (r_zext),
        .o_result  (w_align_result)
    );

    assign w_load_data = r_wr ? '0 : w_align_result;

    // Drive request and pipeline-handshake outputs from the current state.
    // While stalled in REQ the captured fields are presented so the request
    // stays stable even if the MEM register is flushed underneath it.
    always_comb begin
        data_sram_req   = 1'b0;
        mem_ready_go    = 1'b0;
        mem_load_result = '0;
        data_sram_wr    = w_live_wr;
        data_sram_size  = w_live_size;
        data_sram_wstrb = w_live_wstrb;
        data_sram_addr  = mem_dram_waddr;
        data_sram_wdata = w_live_wdata;
        case (r_state)
            ST_IDLE: begin
                data_sram_req = w_acc;
                mem_ready_go  = ~w_acc;
            end
            ST_REQ: begin
                data_sram_req   = 1'b1;
                data_sram_wr    = r_wr;
                data_sram_size  = r_size;
                data_sram_wstrb = r_wstrb;
                data_sram_addr  = r_addr;
                data_sram_wdata = r_wdata;
            end
            ST_WAIT: begin
                mem_ready_go = data_sram_data_ok;
                if (data_sram_data_ok) begin
                    mem_load_result = w_load_data;
                end
            end
            ST_DONE: begin
                mem_ready_go    = 1'b1;
                mem_load_result = r_result_buf;
            end
            default: ;
        endcase
    end

    // Access FSM: issue, wait for acceptance, wait for response, buffer
    // while WB stalls, and discard responses belonging to flushed accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cancel_pending <= 1'b0;
            r_result_buf     <= '0;
            r_wr             <= 1'b0;
            r_size           <= '0;
            r_wstrb          <= '0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_rd_num         <= '0;
            r_sext           <= 1'b0;
            r_zext           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cancel_pending <= 1'b0;
                    if (w_acc) begin
                        r_wr     <= w_live_wr;
                        r_size   <= w_live_size;
                        r_wstrb  <= w_live_wstrb;
                        r_addr   <= mem_dram_waddr;
                        r_wdata  <= w_live_wdata;
                        r_rd_num <= mem_rdram_num;
                        r_sext   <= mem_rdram_need_signed_extend;
                        r_zext   <= mem_rdram_need_zero_extend;
                        r_state  <= data_sram_addr_ok ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (data_sram_addr_ok) begin
                        r_cancel_pending <= 1'b0;
                        if (w_flush | r_cancel_pending) begin
                            r_state <= data_sram_data_ok ? ST_IDLE : ST_CANCEL;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_flush) begin
                        r_cancel_pending <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (w_flush | wb_allowin) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state      <= ST_DONE;
                            r_result_buf <= w_load_data;
                        end
                    end else if (w_flush) begin
                        r_state <= ST_CANCEL;
                    end
                end
                ST_DONE: begin
                    if (w_flush | wb_allowin) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CANCEL: begin
                    if (data_sram_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dram_access.sv
// Directed self-checking bench for mem_dram_access.
module tb_mem_dram_access;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_dram_re;
    logic        mem_dram_we;
    logic [31:0] mem_dram_waddr;
    logic [31:0] mem_dram_wdata;
    logic [1:0]  mem_rdram_num;
    logic [1:0]  mem_wdram_num;
    logic        mem_rdram_need_signed_extend;
    logic        mem_rdram_need_zero_extend;
    logic        mem_ex;
    logic        wb_ex;
    logic        wb_is_ertn;
    logic        wb_allowin;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_ready_go;
    logic [31:0] mem_load_result;

    int unsigned n_checks;
    int unsigned n_fail;

    mem_dram_access dut (
        .clk                          (clk),
        .rst                          (rst),
        .mem_valid                    (mem_valid),
        .mem_dram_re                  (mem_dram_re),
        .mem_dram_we                  (mem_dram_we),
        .mem_dram_waddr               (mem_dram_waddr),
        .mem_dram_wdata               (mem_dram_wdata),
        .mem_rdram_num                (mem_rdram_num),
        .mem_wdram_num                (mem_wdram_num),
        .mem_rdram_need_signed_extend (mem_rdram_need_signed_extend),
        .mem_rdram_need_zero_extend   (mem_rdram_need_zero_extend),
        .mem_ex                       (mem_ex),
        .wb_ex                        (wb_ex),
        .wb_is_ertn                   (wb_is_ertn),
        .wb_allowin                   (wb_allowin),
        .data_sram_req                (data_sram_req),
        .data_sram_wr                 (data_sram_wr),
        .data_sram_size               (data_sram_size),
        .data_sram_wstrb              (data_sram_wstrb),
        .data_sram_addr               (data_sram_addr),
        .data_sram_wdata              (data_sram_wdata),
        .data_sram_addr_ok            (data_sram_addr_ok),
        .data_sram_data_ok            (data_sram_data_ok),
        .data_sram_rdata              (data_sram_rdata),
        .mem_ready_go                 (mem_ready_go),
        .mem_load_result              (mem_load_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Load with addr_ok in the issue cycle and data_ok one cycle later.
    task automatic load_fast(input string tag, input logic [31:0] addr, input logic [1:0] num,
                             input logic s, input logic z, input logic [31:0] rd,
                             input logic [31:0] exp);
        mem_valid = 1'b1; mem_dram_re = 1'b1; mem_dram_we = 1'b0;
        mem_rdram_num = num; mem_rdram_need_signed_extend = s; mem_rdram_need_zero_extend = z;
        mem_dram_waddr = addr; data_sram_addr_ok = 1'b1;
        #2;
        chk({tag, "_req"}, {31'h0, data_sram_req}, 32'd1);
        chk({tag, "_wr"}, {31'h0, data_sram_wr}, 32'd0);
        chk({tag, "_size"}, {30'h0, data_sram_size}, {30'h0, num});
        chk({tag, "_wstrb"}, {28'h0, data_sram_wstrb}, 32'd0);
        chk({tag, "_addr"}, data_sram_addr, addr);
        chk({tag, "_rg0"}, {31'h0, mem_ready_go}, 32'd0);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        #2;
        chk({tag, "_rg1"}, {31'h0, mem_ready_go}, 32'd1);
        chk({tag, "_res"}, mem_load_result, exp);
        cyc();
        data_sram_data_ok = 1'b0; mem_valid = 1'b0; mem_dram_re = 1'b0;
        mem_rdram_need_signed_extend = 1'b0; mem_rdram_need_zero_extend = 1'b0;
    endtask

    task automatic store_fast(input string tag, input logic [31:0] addr, input logic [1:0] num,
                              input logic [31:0] wd, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata);
        mem_valid = 1'b1; mem_dram_re = 1'b0; mem_dram_we = 1'b1;
        mem_wdram_num = num; mem_dram_wdata = wd; mem_dram_waddr = addr;
        data_sram_addr_ok = 1'b1;
        #2;
        chk({tag, "_req"}, {31'h0, data_sram_req}, 32'd1);
        chk({tag, "_wr"}, {31'h0, data_sram_wr}, 32'd1);
        chk({tag, "_size"}, {30'h0, data_sram_size}, {30'h0, num});
        chk({tag, "_wstrb"}, {28'h0, data_sram_wstrb}, {28'h0, exp_strb});
        chk({tag, "_wdata"}, data_sram_wdata, exp_wdata);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        #2;
        chk({tag, "_rg"}, {31'h0, mem_ready_go}, 32'd1);
        chk({tag, "_res"}, mem_load_result, 32'd0);
        cyc();
        data_sram_data_ok = 1'b0; mem_valid = 1'b0; mem_dram_we = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        mem_valid = 1'b0; mem_dram_re = 1'b0; mem_dram_we = 1'b0;
        mem_dram_waddr = '0; mem_dram_wdata = '0;
        mem_rdram_num = '0; mem_wdram_num = '0;
        mem_rdram_need_signed_extend = 1'b0; mem_rdram_need_zero_extend = 1'b0;
        mem_ex = 1'b0; wb_ex = 1'b0; wb_is_ertn = 1'b0; wb_allowin = 1'b1;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;

        cyc();
        cyc();
        #2;
        chk("rst_req", {31'h0, data_sram_req}, 32'd0);
        chk("rst_rg", {31'h0, mem_ready_go}, 32'd1);
        chk("rst_res", mem_load_result, 32'd0);
        chk("rst_wstrb", {28'h0, data_sram_wstrb}, 32'd0);
        rst = 1'b0;
        cyc();

        load_fast("ldw", 32'h1C00_0004, 2'd2, 1'b0, 1'b0, 32'h8765_4321, 32'h8765_4321);
        load_fast("ldb_s", 32'h1C00_0003, 2'd0, 1'b1, 1'b0, 32'h8012_3456, 32'hFFFF_FF80);
        load_fast("ldb_z", 32'h1C00_0003, 2'd0, 1'b0, 1'b1, 32'h8012_3456, 32'h0000_0080);
        load_fast("ldh_z", 32'h1C00_0000, 2'd1, 1'b0, 1'b1, 32'h1234_F00D, 32'h0000_F00D);
        store_fast("sth", 32'h1C00_0002, 2'd1, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_fast("stb", 32'h1C00_0001, 2'd0, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
        store_fast("stw", 32'h1C00_0008, 2'd2, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // addr_ok withheld 3 cycles, then WB stalls for 2 cycles
        mem_valid = 1'b1; mem_dram_re = 1'b1; mem_rdram_num = 2'd1;
        mem_rdram_need_signed_extend = 1'b1; mem_dram_waddr = 32'h1C00_0006;
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_req", {31'h0, data_sram_req}, 32'd1);
            chk("stall_addr", data_sram_addr, 32'h1C00_0006);
            chk("stall_size", {30'h0, data_sram_size}, 32'd1);
            chk("stall_rg", {31'h0, mem_ready_go}, 32'd0);
            cyc();
        end
        data_sram_addr_ok = 1'b1;
        #2;
        chk("stall_req4", {31'h0, data_sram_req}, 32'd1);
        chk("stall_addr4", data_sram_addr, 32'h1C00_0006);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9ABC_1234;
        wb_allowin = 1'b0;
        #2;
        chk("done_rg0", {31'h0, mem_ready_go}, 32'd1);
        chk("done_res0", mem_load_result, 32'hFFFF_9ABC);
        cyc();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #2;
        chk("done_rg1", {31'h0, mem_ready_go}, 32'd1);
        chk("done_res1", mem_load_result, 32'hFFFF_9ABC);
        chk("done_req", {31'h0, data_sram_req}, 32'd0);
        cyc();
        wb_allowin = 1'b1;
        #2;
        chk("done_rg2", {31'h0, mem_ready_go}, 32'd1);
        chk("done_res2", mem_load_result, 32'hFFFF_9ABC);
        cyc();
        mem_valid = 1'b0; mem_dram_re = 1'b0; mem_rdram_need_signed_extend = 1'b0;
        #2;
        chk("done_idle_rg", {31'h0, mem_ready_go}, 32'd1);
        cyc();

        // Flush while waiting for data; the late response is discarded
        mem_valid = 1'b1; mem_dram_re = 1'b1; mem_rdram_num = 2'd2;
        mem_dram_waddr = 32'h1C00_0010; data_sram_addr_ok = 1'b1;
        #2;
        chk("cw_req", {31'h0, data_sram_req}, 32'd1);
        cyc();
        data_sram_addr_ok = 1'b0; wb_ex = 1'b1;
        #2;
        chk("cw_flush_rg", {31'h0, mem_ready_go}, 32'd0);
        chk("cw_flush_req", {31'h0, data_sram_req}, 32'd0);
        cyc();
        wb_ex = 1'b0; mem_dram_waddr = 32'h1C00_0020;
        #2;
        chk("cw_cancel_req", {31'h0, data_sram_req}, 32'd0);
        chk("cw_cancel_rg", {31'h0, mem_ready_go}, 32'd0);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #2;
        chk("cw_drop_req", {31'h0, data_sram_req}, 32'd0);
        chk("cw_drop_rg", {31'h0, mem_ready_go}, 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        load_fast("cw_next", 32'h1C00_0020, 2'd2, 1'b0, 1'b0, 32'h1122_3344, 32'h1122_3344);

        // Exception suppresses the access
        mem_valid = 1'b1; mem_dram_re = 1'b1; mem_ex = 1'b1; mem_dram_waddr = 32'h1C00_0040;
        #2;
        chk("mex_req", {31'h0, data_sram_req}, 32'd0);
        chk("mex_rg", {31'h0, mem_ready_go}, 32'd1);
        cyc();
        #2;
        chk("mex_req2", {31'h0, data_sram_req}, 32'd0);
        cyc();
        mem_valid = 1'b0; mem_dram_re = 1'b0; mem_ex = 1'b0;

        // Flush while the request is not yet accepted
        mem_valid = 1'b1; mem_dram_re = 1'b1; mem_rdram_num = 2'd2;
        mem_dram_waddr = 32'h1C00_0030; data_sram_addr_ok = 1'b0;
        #2;
        chk("cr_req0", {31'h0, data_sram_req}, 32'd1);
        cyc();
        wb_ex = 1'b1;
        #2;
        chk("cr_req1", {31'h0, data_sram_req}, 32'd1);
        chk("cr_rg1", {31'h0, mem_ready_go}, 32'd0);
        cyc();
        wb_ex = 1'b0; mem_valid = 1'b0; mem_dram_re = 1'b0; mem_dram_waddr = 32'h0;
        data_sram_addr_ok = 1'b1;
        #2;
        chk("cr_req2", {31'h0, data_sram_req}, 32'd1);
        chk("cr_addr2", data_sram_addr, 32'h1C00_0030);
        cyc();
        data_sram_addr_ok = 1'b0;
        #2;
        chk("cr_cancel_req", {31'h0, data_sram_req}, 32'd0);
        chk("cr_cancel_rg", {31'h0, mem_ready_go}, 32'd0);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_0BAD;
        #2;
        chk("cr_drop_rg", {31'h0, mem_ready_go}, 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        #2;
        chk("cr_idle_rg", {31'h0, mem_ready_go}, 32'd1);
        chk("cr_idle_req", {31'h0, data_sram_req}, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dram_access.md
# mem_dram_access

Data-memory access engine for the MEM stage of the five-stage LoongArch pipeline. It sits on the output side of the EXE→MEM pipeline register and consumes the held access fields: load/store enables, address, store data, access size and extension flags. It drives the data SRAM-like request/response interface, aligns and extends load data, and produces `mem_ready_go` so the pipeline advances only when the access has completed. It also absorbs responses that are still outstanding after a writeback-stage flush (`wb_ex` / `wb_is_ertn`).

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  MEM stage holds a valid instruction.
- `mem_dram_re` / `mem_dram_we`  in  1 / 1  load / store request from the MEM register.
- `mem_dram_waddr`  in  32  byte address, shared by loads and stores.
- `mem_dram_wdata`  in  32  store data, right-aligned.
- `mem_rdram_num` / `mem_wdram_num`  in  2 / 2  load / store size: 0 = byte, 1 = half, 2 = word.
- `mem_rdram_need_signed_extend` / `mem_rdram_need_zero_extend`  in  1 / 1  load extension mode.
- `mem_ex`  in  1  instruction already carries an exception (ADEF, ALE, INE, BRK, SYS, INT); suppresses the access.
- `wb_ex`, `wb_is_ertn`  in  1 / 1  pipeline flush.
- `wb_allowin`  in  1  WB stage accepts this cycle.
- `data_sram_req`, `data_sram_wr`  out  1 / 1  request valid; write when 1.
- `data_sram_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_sram_wstrb`  out  4  byte enables; 0 on reads.
- `data_sram_addr`, `data_sram_wdata`  out  32 / 32  request address and lane-replicated data.
- `data_sram_addr_ok`, `data_sram_data_ok`  in  1 / 1  request accepted; response valid.
- `data_sram_rdata`  in  32  raw read word.
- `mem_ready_go`  out  1  MEM instruction may leave the stage.
- `mem_load_result`  out  32  aligned and extended load data.

## Operation
- `acc = mem_valid & (mem_dram_re | mem_dram_we) & ~mem_ex & ~wb_ex & ~wb_is_ertn`.
- States:
  - IDLE: `data_sram_req = acc`. On `addr_ok` → WAIT, otherwise → REQ.
  - REQ: `req` held at 1, fields stable. On `addr_ok` → WAIT.
  - WAIT: on `data_ok` with `wb_allowin` → IDLE; with `~wb_allowin` → DONE and latch the load result.
  - DONE: `mem_ready_go = 1` with buffered result. On `wb_allowin` → IDLE.
  - CANCEL: on `data_ok` → IDLE; the response is discarded.
- `mem_ready_go`:
  - 1 in IDLE when `~acc` (non-memory instruction, exception, or bubble).
  - 1 in WAIT on the `data_ok` cycle.
  - 1 in DONE.
  - 0 otherwise.
- Flush (`wb_ex | wb_is_ertn`):
  - IDLE, DONE → IDLE.
  - WAIT → CANCEL, unless `data_ok` arrives in the same cycle, then → IDLE.
  - REQ: `req` stays asserted until `addr_ok`, then → CANCEL (if `data_ok` is also present that cycle → IDLE). A set `cancel_pending` flag records the flush until then.
  - While the flush is high, `mem_ready_go` has no effect.
- CANCEL never issues a new request. `acc` is ignored until the state returns to IDLE.
- Store encoding, with `a = addr[1:0]`:
  - byte: `wstrb = 4'b0001 << a`, `wdata = {4{wdata[7:0]}}`.
  - half: `wstrb = 4'b0011 << {a[1],1'b0}`, `wdata = {2{wdata[15:0]}}`.
  - word: `wstrb = 4'b1111`, `wdata` unchanged.
- `data_sram_size` = `mem_wdram_num` on writes, `mem_rdram_num` on reads. `data_sram_addr = mem_dram_waddr`, unmasked.
- Load alignment: byte = `rdata >> (8*a)`, bits [7:0]; half = `a[1]` ? `rdata[31:16]` : `rdata[15:0]`; word = `rdata`.
- Load extension: signed flag → sign-extend; zero flag → zero-extend; neither → word. Stores return `mem_load_result = 0`.
- Size 3 is illegal and is treated as word.

## Timing
- Reset values: state IDLE, `cancel_pending` 0, result buffer 0, `data_sram_req` 0. All other outputs follow the combinational decode of IDLE with `acc = 0`.
- Best-case latency: `addr_ok` in the issue cycle and `data_ok` one cycle later gives 2 cycles from MEM entry to `mem_ready_go`.
- `data_sram_req` must never drop before `addr_ok`, including on reset-free flush.
- At most one request is outstanding. `rst` mid-access returns to IDLE immediately; the memory side is reset by the same `rst`.

## Structure
- A shared package holds the size encodings (`SZ_B/SZ_H/SZ_W`), the state encoding, and the load-extend function.
- One sub-module, `mem_load_align` (combinational align and extend from `rdata`, `a`, size, extension flags), is also reused for buffering.

## Test plan
- Word load, addr 0x1C00_0004, `addr_ok` immediate, `data_ok` +1 with rdata 0x8765_4321 → `mem_ready_go` on cycle 2, result 0x8765_4321.
- Signed byte load, addr …03, rdata 0x80xx_xxxx → result 0xFFFF_FF80; zero-extended → 0x0000_0080.
- Half store 0x0000_ABCD to addr …02 → `wstrb` 4'b1100, `wdata` 0xABCD_ABCD, `wr` 1, `size` 1.
- `addr_ok` withheld 3 cycles → `req` and fields stable for 4 cycles. `data_ok` with `wb_allowin` = 0 for 2 cycles → DONE holds result, `mem_ready_go` = 1 throughout.
- `wb_ex` in WAIT, `data_ok` 2 cycles later → no `mem_ready_go`, no new `req` until IDLE, next load unaffected by the discarded data.
- `mem_ex` = 1 on a load → `req` never asserted, `mem_ready_go` = 1 same cycle.
